cfs_algn_core: RTL and testbench
================================

Name: cfs_algn_core

Overview:
Parametrised byte-aligning datapath core for the aligner environment.
- Accepts memory-data (MD) RX transfers of variable byte size and offset on a valid/ready handshake.
- Accumulates the valid bytes in order.
- Re-emits them as TX transfers of the configured size at the configured offset.
- Generalises the fixed 32-bit aligner to any byte-multiple data width, and adds config-error and drop reporting.

Parameters:
- DATA_WIDTH, 32, bus width in bits. Multiple of 8, range 8..128. BYTES = DATA_WIDTH/8 is derived and is not overridable.
- DROP_CNT_WIDTH, 8, width of the drop counter. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- ctrl_offset  in  OFFW=$clog2(BYTES) (min 1)  TX lane offset
- ctrl_size  in  SIZEW=$clog2(BYTES)+1  TX transfer size in bytes
- rx_valid  in  1  RX transfer valid
- rx_data  in  DATA_WIDTH  RX data; byte k occupies bits 8k+7:8k
- rx_offset  in  OFFW  first valid RX lane
- rx_size  in  SIZEW  number of valid RX bytes
- rx_ready  out  1  core can accept an RX transfer
- rx_err  out  1  one-cycle pulse: previous accepted RX transfer was illegal
- tx_valid  out  1  TX transfer valid
- tx_data  out  DATA_WIDTH  TX data; non-payload lanes are zero
- tx_offset  out  OFFW  TX offset (latched ctrl_offset)
- tx_size  out  SIZEW  TX size (latched ctrl_size)
- tx_ready  in  1  TX sink accepts
- cfg_err  out  1  live ctrl_size/ctrl_offset combination is illegal
- level  out  $clog2(2*BYTES)+1  bytes currently held in the accumulator

Behaviour:
Reset (reset_n low at a clk edge):
- Accumulator is emptied; level=0.
- Outputs: rx_ready=0, rx_err=0, tx_valid=0, tx_data=0, tx_offset=0, tx_size=0.
- cfg_err is combinational from the ctrl inputs and is not affected by reset.
- Reset mid-transfer discards all held bytes and any pending TX. Nothing is replayed.

Legality (same rule for RX and config):
- A (size, offset) pair is legal iff size != 0, size <= BYTES, offset+size <= BYTES, and offset % size == 0.

Accumulator:
- Byte FIFO with capacity 2*BYTES.
- rx_ready = registered (level <= BYTES). It is 1 from the first cycle after reset deasserts.

RX accept:
- An RX transfer is accepted when rx_valid && rx_ready.
- Legal transfer: lanes rx_offset .. rx_offset+rx_size-1 are pushed in ascending lane order.
- Illegal transfer: nothing is pushed, level is unchanged, and rx_err=1 in the next cycle only.

TX state machine (TX_IDLE, TX_VALID):
- TX_IDLE -> TX_VALID when level >= ctrl_size and cfg_err=0.
  - On this transition ctrl_size and ctrl_offset are latched into tx_size and tx_offset.
  - The oldest tx_size bytes are placed in ascending order starting at lane tx_offset; all other lanes are 0.
- In TX_VALID, tx_data, tx_offset and tx_size are held stable until tx_ready=1.
- On handshake, tx_size bytes are popped.
  - The FSM returns to TX_IDLE, or re-enters TX_VALID in the next cycle if the condition still holds.
- Latency: bytes accepted at edge N can appear on TX with tx_valid high after edge N+1 at the earliest. Throughput is one TX per 2 cycles.
- ctrl changes while in TX_VALID do not affect the pending transfer.

Boundary conditions:
- Simultaneous push and pop in one cycle: level_next = level + rx_size - tx_size.
- While cfg_err=1, tx_valid stays 0 and RX continues until rx_ready drops.
- Level can never exceed 2*BYTES because RX is only accepted while level <= BYTES.

Optional Feature:
Macro: CFS_ALGN_CORE_DROP_CNT_EN
- Defined: adds output port drop_cnt [DROP_CNT_WIDTH].
  - Reset value 0.
  - Increments on each illegal accepted RX transfer.
  - Saturates at all-ones.
- Undefined: the port and counter do not exist. rx_err behaviour is identical in both cases.

Decomposition:
- Package cfs_algn_pkg: tx FSM state enum; OFFW and SIZEW width functions; legality check function cfs_algn_is_legal(size, offset, bytes).
- Sub-module cfs_algn_byte_fifo holds the byte accumulator: multi-byte push/pop, level, parametrised by byte count.
- Top-level core holds the handshakes, the lane shifting and the FSM.

Test Plan:
All scenarios use DATA_WIDTH=32.
1. ctrl size=4, off=0. RX 0x11@off0, 0x22@off1, 0x33@off2, 0x44@off3, each size 1 -> one TX: data=0x44332211, size=4, off=0.
2. ctrl size=2, off=2. RX 0xDDCCBBAA, size 4, off 0 -> TX 0xBBAA0000 then 0xDDCC0000, each size=2, off=2.
3. RX size=2, off=1 (illegal) -> rx_err pulses exactly one cycle, level stays 0, no TX. With CFS_ALGN_CORE_DROP_CNT_EN: drop_cnt=1. After 300 illegal transfers with DROP_CNT_WIDTH=8: drop_cnt=255.
4. tx_ready held low 5 cycles while RX streams size-4 transfers -> tx_data stable for all 5 cycles, rx_ready drops once level=8, and no bytes are lost after tx_ready rises.
5. ctrl size=3, off=1 (cfg_err=1), level=4 -> tx_valid stays 0. Set size=4, off=0 -> TX appears within 2 cycles.
6. level=3 then reset_n low for 1 cycle -> level=0, tx_valid=0, rx_ready=1 after the next edge, and the following TX contains no stale bytes.

Source files
------------

// File: rtl/cfs_algn_pkg.sv
// Shared FSM state encoding, width helpers and the (size, offset) legality rule
// used by the cfs_algn byte aligner.
package cfs_algn_pkg;

  typedef logic [0:0] cfs_algn_tx_state_t;

  localparam cfs_algn_tx_state_t TX_IDLE  = 1'b0;
  localparam cfs_algn_tx_state_t TX_VALID = 1'b1;

  function automatic int cfs_algn_offw(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

  function automatic int cfs_algn_sizew(input int bytes);
    return $clog2(bytes) + 1;
  endfunction

  // A transfer must fit in the bus and start on a multiple of its own size.
  function automatic logic cfs_algn_is_legal(input int unsigned size,
                                             input int unsigned offset,
                                             input int unsigned bytes);
    if (size == 0) return 1'b0;
    return (size <= bytes) && (offset + size <= bytes) && (offset % size == 0);
  endfunction

endpackage

// File: rtl/cfs_algn_byte_fifo.sv
// Byte accumulator for the aligner: up to BYTES bytes pushed and popped per cycle,
// oldest byte always sits in lane 0 of the head word.
module cfs_algn_byte_fifo #(
  parameter int BYTES = 4,
  parameter int SIZEW = 3,
  parameter int LVLW  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [SIZEW-1:0]   push_cnt,
  input  logic [8*BYTES-1:0] push_data,
  input  logic [SIZEW-1:0]   pop_cnt,
  output logic [LVLW-1:0]    level,
  output logic [LVLW-1:0]    level_nxt,
  output logic [8*BYTES-1:0] head
);

  localparam int CAPW = 16 * BYTES;

  logic [CAPW-1:0]    buf_q;
  logic [CAPW-1:0]    kept;
  logic [CAPW-1:0]    pushed;
  logic [CAPW-1:0]    keep_mask;
  logic [8*BYTES-1:0] push_mask;
  logic [LVLW-1:0]    keep_cnt;

  // Shift out popped bytes, then append the new bytes right behind the survivors;
  // masking by count keeps stale storage from ever leaking into the head.
  always_comb begin
    keep_cnt  = level - LVLW'(pop_cnt);
    keep_mask = ~({CAPW{1'b1}} << (8 * 32'(keep_cnt)));
    push_mask = ~({8*BYTES{1'b1}} << (8 * 32'(push_cnt)));
    kept      = (buf_q >> (8 * 32'(pop_cnt))) & keep_mask;
    pushed    = CAPW'(push_data & push_mask) << (8 * 32'(keep_cnt));
    level_nxt = keep_cnt + LVLW'(push_cnt);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) level <= '0;
    else          level <= level_nxt;
  end

  always_ff @(posedge clk) begin
    buf_q <= kept | pushed;
  end

  assign head = buf_q[8*BYTES-1:0];

endmodule

// File: rtl/cfs_algn_core.sv
// Byte-aligning core: accumulates RX bytes and re-emits them at the configured size/offset.
// Optional saturating drop counter is compiled in with CFS_ALGN_CORE_DROP_CNT_EN.
module cfs_algn_core
  import cfs_algn_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int DROP_CNT_WIDTH = 8,
  localparam int BYTES          = DATA_WIDTH / 8,
  localparam int OFFW           = cfs_algn_offw(BYTES),
  localparam int SIZEW          = cfs_algn_sizew(BYTES),
  localparam int LVLW           = $clog2(2 * BYTES) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [OFFW-1:0]       ctrl_offset,
  input  logic [SIZEW-1:0]      ctrl_size,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic [OFFW-1:0]       rx_offset,
  input  logic [SIZEW-1:0]      rx_size,
  output logic                  rx_ready,
  output logic                  rx_err,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [OFFW-1:0]       tx_offset,
  output logic [SIZEW-1:0]      tx_size,
  input  logic                  tx_ready,
  output logic                  cfg_err,
  output logic [LVLW-1:0]       level
`ifdef CFS_ALGN_CORE_DROP_CNT_EN
  ,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
`endif
);

  if ((DATA_WIDTH % 8 != 0) || (DATA_WIDTH < 8) || (DATA_WIDTH > 128) ||
      (DROP_CNT_WIDTH < 1)) begin : g_param_check
    $error("cfs_algn_core: unsupported DATA_WIDTH or DROP_CNT_WIDTH");
  end

  cfs_algn_tx_state_t    state;
  logic                  accept;
  logic                  rx_legal;
  logic [SIZEW-1:0]      push_cnt;
  logic [SIZEW-1:0]      pop_cnt;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] payload;
  logic [LVLW-1:0]       level_nxt;

  assign cfg_err   = !cfs_algn_is_legal(32'(ctrl_size), 32'(ctrl_offset), BYTES);
  assign rx_legal  = cfs_algn_is_legal(32'(rx_size), 32'(rx_offset), BYTES);
  assign accept    = rx_valid && rx_ready;
  assign push_cnt  = (accept && rx_legal) ? rx_size : '0;
  assign push_data = rx_data >> (8 * 32'(rx_offset));
  assign pop_cnt   = (state == TX_VALID && tx_ready) ? tx_size : '0;
  assign tx_valid  = (state == TX_VALID);
  assign payload   = head & ~({DATA_WIDTH{1'b1}} << (8 * 32'(ctrl_size)));

  cfs_algn_byte_fifo #(
    .BYTES (BYTES),
    .SIZEW (SIZEW),
    .LVLW  (LVLW)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop_cnt   (pop_cnt),
    .level     (level),
    .level_nxt (level_nxt),
    .head      (head)
  );

  // rx_ready tracks the next level so a second push can never overfill the store.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= TX_IDLE;
      rx_ready  <= 1'b0;
      rx_err    <= 1'b0;
      tx_data   <= '0;
      tx_offset <= '0;
      tx_size   <= '0;
    end else begin
      rx_ready <= (level_nxt <= LVLW'(BYTES));
      rx_err   <= accept && !rx_legal;
      if (state == TX_IDLE) begin
        if (level >= LVLW'(ctrl_size) && !cfg_err) begin
          state     <= TX_VALID;
          tx_size   <= ctrl_size;
          tx_offset <= ctrl_offset;
          tx_data   <= payload << (8 * 32'(ctrl_offset));
        end
      end else if (tx_ready) begin
        state <= TX_IDLE;
      end
    end
  end

`ifdef CFS_ALGN_CORE_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (accept && !rx_legal && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cfs_algn_core.sv
// Self-checking bench for cfs_algn_core (DATA_WIDTH=32) against a byte-queue reference model.
module tb_cfs_algn_core;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [1:0]  ctrl_offset;
  logic [2:0]  ctrl_size;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic [1:0]  rx_offset;
  logic [2:0]  rx_size;
  logic        rx_ready;
  logic        rx_err;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic [1:0]  tx_offset;
  logic [2:0]  tx_size;
  logic        tx_ready;
  logic        cfg_err;
  logic [3:0]  level;
`ifdef CFS_ALGN_CORE_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  cfs_algn_core #(.DATA_WIDTH(32), .DROP_CNT_WIDTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ctrl_offset (ctrl_offset),
    .ctrl_size   (ctrl_size),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_offset   (rx_offset),
    .rx_size     (rx_size),
    .rx_ready    (rx_ready),
    .rx_err      (rx_err),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_offset   (tx_offset),
    .tx_size     (tx_size),
    .tx_ready    (tx_ready),
    .cfg_err     (cfg_err),
    .level       (level)
`ifdef CFS_ALGN_CORE_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  q[$];
  int          ctrl_sz;
  int          ctrl_off;
  int          drop_m = 0;
  bit          hs_seen;
  bit          exp_err;
  logic [31:0] hs_data;
  logic [31:0] hs_exp;
  logic [2:0]  hs_size;
  logic [1:0]  hs_off;

  function automatic bit legal(input int sz, input int off);
    if (sz == 0) return 1'b0;
    return (sz <= 4) && (off + sz <= 4) && (off % sz == 0);
  endfunction

  task automatic ctrl_set(input int sz, input int off);
    ctrl_sz = sz; ctrl_off = off;
    ctrl_size = 3'(sz); ctrl_offset = 2'(off);
  endtask

  task automatic rx_drive(input logic v, input logic [31:0] d, input int off, input int sz);
    rx_valid = v; rx_data = d; rx_offset = 2'(off); rx_size = 3'(sz);
  endtask

  // Advance one clock; the model applies the handshakes seen just before the edge.
  task automatic tick();
    bit acc, hs, in_rst, leg;
    logic [31:0] sd, td;
    logic [2:0] ts;
    logic [1:0] to;
    int so, ss;
    acc = rx_valid && rx_ready; hs = tx_valid && tx_ready; in_rst = !reset_n;
    sd = rx_data; so = int'(rx_offset); ss = int'(rx_size);
    td = tx_data; ts = tx_size; to = tx_offset;
    @(posedge clk);
    hs_seen = 1'b0; exp_err = 1'b0;
    if (in_rst) begin
      q.delete(); drop_m = 0;
    end else begin
      if (hs) begin
        hs_seen = 1'b1; hs_data = td; hs_size = ts; hs_off = to; hs_exp = '0;
        for (int i = 0; i < ctrl_sz; i++)
          if (q.size() > 0) hs_exp |= 32'(q.pop_front()) << (8 * (ctrl_off + i));
      end
      leg = legal(ss, so);
      if (acc && leg) for (int i = 0; i < ss; i++) q.push_back(8'(sd >> (8 * (so + i))));
      if (acc && !leg) begin exp_err = 1'b1; if (drop_m < 255) drop_m++; end
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tx_ready = 1'b0; rx_drive(1'b0, '0, 0, 0); ctrl_set(4, 0);
    tick(); tick();
    tests++; if (level !== 4'd0) begin fails++; $display("FAIL reset_level: got %0d expected 0", level); end
    tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL reset_rx_ready: got %b expected 0", rx_ready); end
    tests++; if (rx_err !== 1'b0 || tx_valid !== 1'b0) begin fails++; $display("FAIL reset_flags: got rx_err=%b tx_valid=%b expected 0 0", rx_err, tx_valid); end
    tests++; if (tx_data !== 32'h0 || tx_size !== 3'd0 || tx_offset !== 2'd0) begin fails++; $display("FAIL reset_tx_fields: got %h/%0d/%0d expected 0/0/0", tx_data, tx_size, tx_offset); end
    ctrl_set(3, 1); #1;
    tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL reset_cfg_err_comb: got %b expected 1", cfg_err); end
    ctrl_set(4, 0); #1;
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL reset_cfg_ok_comb: got %b expected 0", cfg_err); end
    reset_n = 1'b1; tick();
    tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL reset_release_rx_ready: got %b expected 1", rx_ready); end
  endtask

  task automatic test_single_bytes();
    logic [31:0] d;
    bit got;
    ctrl_set(4, 0); tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = $urandom(); d[8*k +: 8] = 8'(8'h11 * (k + 1));
      rx_drive(1'b1, d, k, 1); tick();
    end
    rx_valid = 1'b0; got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin tick(); got = hs_seen; end
    tests++;
    if (!got) begin fails++; $display("FAIL single_bytes_tx: got no TX expected one within 6 cycles"); end
    else begin
      tests++; if (hs_data !== 32'h44332211) begin fails++; $display("FAIL single_bytes_data: got %h expected 44332211", hs_data); end
      tests++; if (hs_data !== hs_exp) begin fails++; $display("FAIL single_bytes_model: got %h expected %h", hs_data, hs_exp); end
      tests++; if (hs_size !== 3'd4 || hs_off !== 2'd0) begin fails++; $display("FAIL single_bytes_fields: got size %0d off %0d expected 4 0", hs_size, hs_off); end
    end
    tests++; if (level !== 4'd0) begin fails++; $display("FAIL single_bytes_level: got %0d expected 0", level); end
  endtask

  task automatic test_split();
    logic [31:0] got_d[2];
    logic [31:0] want[2];
    int n;
    want[0] = 32'hBBAA0000; want[1] = 32'hDDCC0000;
    ctrl_set(2, 2); tx_ready = 1'b1;
    rx_drive(1'b1, 32'hDDCCBBAA, 0, 4); tick(); rx_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 10 && n < 2; c++) begin
      tick();
      if (hs_seen) begin
        got_d[n] = hs_data; n++;
        tests++; if (hs_size !== 3'd2 || hs_off !== 2'd2) begin fails++; $display("FAIL split_fields: got size %0d off %0d expected 2 2", hs_size, hs_off); end
      end
    end
    tests++;
    if (n != 2) begin fails++; $display("FAIL split_count: got %0d TX expected 2", n); end
    else for (int i = 0; i < 2; i++) begin
      tests++; if (got_d[i] !== want[i]) begin fails++; $display("FAIL split_data%0d: got %h expected %h", i, got_d[i], want[i]); end
    end
  endtask

  task automatic test_illegal();
    int s, o;
    tx_ready = 1'b1; ctrl_set(4, 0);
    rx_drive(1'b1, $urandom(), 1, 2); tick(); rx_valid = 1'b0;
    tests++; if (rx_err !== 1'b1 || level !== 4'd0) begin fails++; $display("FAIL illegal_pulse: got rx_err=%b level=%0d expected 1 0", rx_err, level); end
    tick();
    tests++; if (rx_err !== 1'b0 || tx_valid !== 1'b0) begin fails++; $display("FAIL illegal_one_cycle: got rx_err=%b tx_valid=%b expected 0 0", rx_err, tx_valid); end
`ifdef CFS_ALGN_CORE_DROP_CNT_EN
    tests++; if (drop_cnt !== 8'd1) begin fails++; $display("FAIL drop_cnt_one: got %0d expected 1", drop_cnt); end
`endif
    for (int i = 0; i < 300; i++) begin
      do begin s = $urandom_range(0, 7); o = $urandom_range(0, 3); end while (legal(s, o));
      rx_drive(1'b1, $urandom(), o, s); tick();
      tests++; if (rx_err !== exp_err || level !== 4'd0) begin fails++; $display("FAIL illegal_stream: got rx_err=%b level=%0d expected %b 0", rx_err, level, exp_err); end
    end
    rx_valid = 1'b0; tick();
    tests++; if (rx_err !== 1'b0) begin fails++; $display("FAIL illegal_stream_end: got %b expected 0", rx_err); end
`ifdef CFS_ALGN_CORE_DROP_CNT_EN
    tests++; if (drop_cnt !== 8'd255 || drop_m != 255) begin fails++; $display("FAIL drop_cnt_sat: got %0d expected 255", drop_cnt); end
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] d0, exp;
    bit was;
    ctrl_set(4, 0); tx_ready = 1'b0;
    rx_drive(1'b1, $urandom(), 0, 4);
    repeat (2) begin tick(); rx_data = $urandom(); end
    tests++; if (level !== 4'd8 || rx_ready !== 1'b0 || tx_valid !== 1'b1) begin fails++; $display("FAIL bp_fill: got level=%0d rx_ready=%b tx_valid=%b expected 8 0 1", level, rx_ready, tx_valid); end
    exp = (q.size() >= 4) ? {q[3], q[2], q[1], q[0]} : 32'hx;
    d0 = tx_data;
    tests++; if (d0 !== exp) begin fails++; $display("FAIL bp_head: got %h expected %h", d0, exp); end
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++; if (tx_valid !== 1'b1 || tx_data !== d0) begin fails++; $display("FAIL bp_stable: got %b/%h expected 1/%h", tx_valid, tx_data, d0); end
      tests++; if (rx_ready !== 1'b0 || level !== 4'd8) begin fails++; $display("FAIL bp_hold: got rx_ready=%b level=%0d expected 0 8", rx_ready, level); end
    end
    tx_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c == 10) rx_valid = 1'b0;
      was = rx_ready; tick(); if (was) rx_data = $urandom();
      tests++; if (level !== 4'(q.size())) begin fails++; $display("FAIL bp_level: got %0d expected %0d", level, q.size()); end
      if (hs_seen) begin
        tests++; if (hs_data !== hs_exp) begin fails++; $display("FAIL bp_data: got %h expected %h", hs_data, hs_exp); end
      end
    end
    tests++; if (level !== 4'd0 || q.size() != 0) begin fails++; $display("FAIL bp_drained: got level=%0d expected 0 (model %0d)", level, q.size()); end
  endtask

  task automatic test_cfg_err();
    bit got, was;
    ctrl_set(3, 1); tx_ready = 1'b1; #1;
    tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL cfg_err_set: got %b expected 1", cfg_err); end
    rx_drive(1'b1, $urandom(), 0, 4);
    for (int c = 0; c < 3; c++) begin
      was = rx_ready; tick(); if (was) rx_data = $urandom();
      tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL cfg_err_no_tx: got %b expected 0", tx_valid); end
    end
    rx_valid = 1'b0; tick();
    tests++; if (level !== 4'd8 || rx_ready !== 1'b0 || tx_valid !== 1'b0) begin fails++; $display("FAIL cfg_err_full: got level=%0d rx_ready=%b tx_valid=%b expected 8 0 0", level, rx_ready, tx_valid); end
    ctrl_set(4, 0); #1;
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL cfg_err_clear: got %b expected 0", cfg_err); end
    got = 1'b0;
    for (int c = 0; c < 2 && !got; c++) begin tick(); got = tx_valid; end
    tests++; if (!got) begin fails++; $display("FAIL cfg_err_recover: got tx_valid=0 expected 1 within 2 cycles"); end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (hs_seen) begin
        tests++; if (hs_data !== hs_exp) begin fails++; $display("FAIL cfg_err_data: got %h expected %h", hs_data, hs_exp); end
      end
    end
    tests++; if (level !== 4'd0 || q.size() != 0) begin fails++; $display("FAIL cfg_err_drained: got level=%0d expected 0", level); end
  endtask

  task automatic test_reset_mid();
    bit got;
    ctrl_set(4, 0); tx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin rx_drive(1'b1, $urandom(), 0, 1); tick(); end
    rx_valid = 1'b0;
    tests++; if (level !== 4'd3) begin fails++; $display("FAIL rst_mid_fill: got %0d expected 3", level); end
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    tests++; if (level !== 4'd0 || tx_valid !== 1'b0 || tx_data !== 32'h0 || rx_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_clear: got level=%0d tx_valid=%b tx_data=%h rx_ready=%b expected 0 0 0 0", level, tx_valid, tx_data, rx_ready); end
    tick();
    tests++; if (rx_ready !== 1'b1 || level !== 4'd0) begin fails++; $display("FAIL rst_mid_ready: got rx_ready=%b level=%0d expected 1 0", rx_ready, level); end
`ifdef CFS_ALGN_CORE_DROP_CNT_EN
    tests++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL rst_mid_drop_cnt: got %0d expected 0", drop_cnt); end
`endif
    rx_drive(1'b1, 32'hA4A3A2A1, 0, 4); tick(); rx_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin tick(); got = hs_seen; end
    tests++;
    if (!got) begin fails++; $display("FAIL rst_mid_tx: got no TX expected one within 6 cycles"); end
    else begin
      tests++; if (hs_data !== 32'hA4A3A2A1) begin fails++; $display("FAIL rst_mid_no_stale: got %h expected a4a3a2a1", hs_data); end
    end
  endtask

  task automatic test_random();
    int ls[8] = '{1, 1, 1, 1, 2, 2, 4, 3};
    int lo[8] = '{0, 1, 2, 3, 0, 2, 0, 0};
    int p;
    bit stall;
    logic [31:0] sd;
    for (int c = 0; c < 600; c++) begin
      if (!tx_valid && $urandom_range(0, 9) == 0) begin
        p = $urandom_range(0, 7);
        if ($urandom_range(0, 4) == 0) ctrl_set($urandom_range(0, 7), $urandom_range(0, 3));
        else ctrl_set(ls[p], lo[p]);
      end
      if (!rx_valid || rx_ready) begin
        p = $urandom_range(0, 7);
        if ($urandom_range(0, 3) == 0) rx_drive($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 3), $urandom_range(0, 7));
        else rx_drive($urandom_range(0, 3) != 0, $urandom(), lo[p], ls[p]);
      end
      tx_ready = ($urandom_range(0, 9) < 7);
      stall = tx_valid && !tx_ready; sd = tx_data;
      tick();
      tests++; if (level !== 4'(q.size())) begin fails++; $display("FAIL rand_level: got %0d expected %0d", level, q.size()); end
      tests++; if (rx_ready !== (q.size() <= 4)) begin fails++; $display("FAIL rand_rx_ready: got %b expected %b", rx_ready, q.size() <= 4); end
      tests++; if (rx_err !== exp_err) begin fails++; $display("FAIL rand_rx_err: got %b expected %b", rx_err, exp_err); end
      tests++; if (cfg_err !== !legal(ctrl_sz, ctrl_off)) begin fails++; $display("FAIL rand_cfg_err: got %b expected %b", cfg_err, !legal(ctrl_sz, ctrl_off)); end
      if (hs_seen) begin
        tests++; if (hs_data !== hs_exp) begin fails++; $display("FAIL rand_tx_data: got %h expected %h", hs_data, hs_exp); end
        tests++; if (32'(hs_size) != ctrl_sz || 32'(hs_off) != ctrl_off) begin fails++; $display("FAIL rand_tx_fields: got %0d/%0d expected %0d/%0d", hs_size, hs_off, ctrl_sz, ctrl_off); end
      end
      if (stall) begin
        tests++; if (tx_valid !== 1'b1 || tx_data !== sd) begin fails++; $display("FAIL rand_tx_hold: got %b/%h expected 1/%h", tx_valid, tx_data, sd); end
      end
    end
    rx_valid = 1'b0; tx_ready = 1'b1; ctrl_set(1, 0);
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      tick();
      if (hs_seen) begin
        tests++; if (hs_data !== hs_exp) begin fails++; $display("FAIL rand_drain_data: got %h expected %h", hs_data, hs_exp); end
      end
    end
    tick(); tick();
    tests++; if (level !== 4'd0 || q.size() != 0) begin fails++; $display("FAIL rand_drained: got level=%0d expected 0 (model %0d)", level, q.size()); end
  endtask

  initial begin
    reset_n = 1'b0; tx_ready = 1'b0;
    rx_drive(1'b0, '0, 0, 0); ctrl_set(4, 0);
    test_reset();
    test_single_bytes();
    test_split();
    test_illegal();
    test_backpressure();
    test_cfg_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected completion before 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
